// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM for the 4-tap FIR datapath. Issues the per-sample
// shift/multiply/accumulate program and coefficient writes as op/src1/src2/dest
// commands. It also reports busy (modwait), accepted samples (cnt_up) and
// arithmetic overflow (err).
module fir_sequencer (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       dr,
  input  logic       lc,
  input  logic [1:0] coeff_num,
  input  logic       overflow,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       cnt_up,
  output logic       modwait,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOADC, S_STORE, S_SH3, S_SH2, S_SH1, S_SH0,
    S_MUL0, S_MUL1, S_ADD1, S_MUL2, S_ADD2, S_MUL3, S_ADD3, S_EIDLE
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD1 = 3'd2,
    OP_LOAD2 = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } op_e;

  state_e     state_q, state_d;
  logic [1:0] coeff_q, coeff_d;
  op_e        op_c;

  // State and captured coefficient index registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      coeff_q <= coeff_d;
    end
  end

  // Next-state logic: dr wins over lc when idle; overflow aborts any MUL/ADD step
  always_comb begin
    state_d = state_q;
    coeff_d = coeff_q;
    case (state_q)
      S_IDLE, S_EIDLE: begin
        if (dr) begin
          state_d = S_STORE;
        end else if (lc) begin
          state_d = S_LOADC;
          coeff_d = coeff_num;
        end
      end
      S_LOADC: state_d = S_IDLE;
      S_STORE: state_d = dr ? S_SH3 : S_EIDLE;
      S_SH3:   state_d = S_SH2;
      S_SH2:   state_d = S_SH1;
      S_SH1:   state_d = S_SH0;
      S_SH0:   state_d = S_MUL0;
      S_MUL0:  state_d = overflow ? S_EIDLE : S_MUL1;
      S_MUL1:  state_d = overflow ? S_EIDLE : S_ADD1;
      S_ADD1:  state_d = overflow ? S_EIDLE : S_MUL2;
      S_MUL2:  state_d = overflow ? S_EIDLE : S_ADD2;
      S_ADD2:  state_d = overflow ? S_EIDLE : S_MUL3;
      S_MUL3:  state_d = overflow ? S_EIDLE : S_ADD3;
      S_ADD3:  state_d = overflow ? S_EIDLE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode of the datapath command and status flags from the state register
  always_comb begin
    op_c    = OP_NOP;
    src1    = '0;
    src2    = '0;
    dest    = '0;
    cnt_up  = 1'b0;
    modwait = 1'b1;
    err     = 1'b0;
    case (state_q)
      S_IDLE:  modwait = 1'b0;
      S_EIDLE: begin
        modwait = 1'b0;
        err     = 1'b1;
      end
      S_LOADC: begin
        op_c = OP_LOAD2;
        dest = 4'd6 + {2'b00, coeff_q};
      end
      S_STORE: begin
        op_c   = OP_LOAD1;
        dest   = 4'd10;
        cnt_up = 1'b1;
      end
      S_SH3: begin op_c = OP_COPY; dest = 4'd4; src1 = 4'd3;  end
      S_SH2: begin op_c = OP_COPY; dest = 4'd3; src1 = 4'd2;  end
      S_SH1: begin op_c = OP_COPY; dest = 4'd2; src1 = 4'd1;  end
      S_SH0: begin op_c = OP_COPY; dest = 4'd1; src1 = 4'd10; end
      S_MUL0: begin op_c = OP_MUL; dest = 4'd0; src1 = 4'd1; src2 = 4'd6; end
      S_MUL1: begin op_c = OP_MUL; dest = 4'd5; src1 = 4'd2; src2 = 4'd7; end
      S_MUL2: begin op_c = OP_MUL; dest = 4'd5; src1 = 4'd3; src2 = 4'd8; end
      S_MUL3: begin op_c = OP_MUL; dest = 4'd5; src1 = 4'd4; src2 = 4'd9; end
      S_ADD1, S_ADD2, S_ADD3: begin
        op_c = OP_ADD;
        dest = 4'd0;
        src1 = 4'd0;
        src2 = 4'd5;
      end
      default: modwait = 1'b0;
    endcase
  end

  assign op = op_c;

endmodule
